// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-read-port register file.
package regfile_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } rf_state_e;

  localparam int DW_DEF     = 32;
  localparam int DEPTH_DEF  = 32;
  localparam int NUM_RD_DEF = 2;

  function automatic int calc_aw(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One registered read port: address decode, zero/out-of-range masking, optional
// write-first forwarding (enabled by defining REGFILE_BYPASS_EN).
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int AW       = calc_aw(DEPTH),
  parameter int ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] mem_i [DEPTH],
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  output logic [DW-1:0] rdata_o
);

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [DW-1:0] rdata_d, rdata_q;
  logic          in_range, is_zero, fwd_hit;

  always_comb begin
    in_range = ({1'b0, addr_i} < (AW+1)'(DEPTH));
    is_zero  = (ZERO_REG != 0) && (addr_i == '0);
    // wr_en_i already excludes dropped writes, so a hit never forwards into entry 0
    fwd_hit  = BYPASS && wr_en_i && (wr_addr_i == addr_i);
    rdata_d  = '0;
    if (en_i && in_range && !is_zero) begin
      rdata_d = fwd_hit ? wr_data_i : mem_i[addr_i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with post-reset clear sequencer. Write-first
// forwarding on read/write collisions is built when REGFILE_BYPASS_EN is defined.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int  DW       = DW_DEF,
  parameter int  DEPTH    = DEPTH_DEF,
  parameter int  NUM_RD   = NUM_RD_DEF,
  parameter int  ZERO_REG = 1,
  localparam int AW       = calc_aw(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_RD*AW-1:0] rsi,
  output logic [NUM_RD*DW-1:0] read_data,
  input  logic [AW-1:0]        rdi,
  input  logic [DW-1:0]        write_data,
  input  logic                 reg_write,
  output logic                 ready
);

  rf_state_e     state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic          clr_en, rd_en, wr_en, wr_in_range, wr_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (state_q == INIT) begin
      idx_d = idx_q + AW'(1);
      if (idx_q == AW'(DEPTH - 1)) state_d = READY;
    end
  end

  always_comb begin
    clr_en      = (state_q == INIT);
    rd_en       = (state_q == READY);
    wr_in_range = ({1'b0, rdi} < (AW+1)'(DEPTH));
    wr_zero     = (ZERO_REG != 0) && (rdi == '0);
    wr_en       = rd_en && reg_write && wr_in_range && !wr_zero;
  end

  assign ready = rd_en;

  // Storage carries no reset; the clear sequencer owns initialisation
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem_q[idx_q] <= '0;
    end else if (wr_en) begin
      mem_q[rdi] <= write_data;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regfile_rdport #(
      .DW      (DW),
      .DEPTH   (DEPTH),
      .AW      (AW),
      .ZERO_REG(ZERO_REG)
    ) u_rdport (
      .clk      (clk),
      .rst_n    (rst_n),
      .en_i     (rd_en),
      .addr_i   (rsi[p*AW +: AW]),
      .mem_i    (mem_q),
      .wr_en_i  (wr_en),
      .wr_addr_i(rdi),
      .wr_data_i(write_data),
      .rdata_o  (read_data[p*DW +: DW])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a default instance (32x32, 2 ports) and a 24x16, 3-port
// instance driven in lockstep and compared each cycle against an array model.
module tb_regfile_mp;

  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [2*AW-1:0] rsi_a;
  logic [3*AW-1:0] rsi_b;
  logic [63:0]   rd_a;
  logic [47:0]   rd_b;
  logic [AW-1:0] rdi;
  logic [31:0]   wdata;
  logic          we;
  logic          rdy_a, rdy_b;

  always #5 clk = ~clk;

  regfile_mp #(.DW(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .rsi(rsi_a), .read_data(rd_a),
    .rdi(rdi), .write_data(wdata), .reg_write(we), .ready(rdy_a)
  );

  regfile_mp #(.DW(16), .DEPTH(24), .NUM_RD(3), .ZERO_REG(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .rsi(rsi_b), .read_data(rd_b),
    .rdi(rdi), .write_data(wdata[15:0]), .reg_write(we), .ready(rdy_b)
  );

  int checks = 0;
  int errors = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP_M = 1'b1;
`else
  localparam bit BYP_M = 1'b0;
`endif

  logic [31:0]   ma [32];
  logic [15:0]   mb [24];
  int            clr_a, clr_b;
  bit            mrdy_a, mrdy_b;
  logic [31:0]   exp_a [2];
  logic [15:0]   exp_b [3];
  logic [AW-1:0] rs [3];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    clr_a = 0; clr_b = 0; mrdy_a = 1'b0; mrdy_b = 1'b0;
    foreach (exp_a[i]) exp_a[i] = '0;
    foreach (exp_b[i]) exp_b[i] = '0;
  endtask

  // One rising edge of the reference: clear progress, or read-then-write in READY.
  task automatic model_edge();
    if (!mrdy_a) begin
      foreach (exp_a[i]) exp_a[i] = '0;
      ma[clr_a] = '0;
      clr_a++;
      if (clr_a == 32) mrdy_a = 1'b1;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (rs[p] == 0)                       exp_a[p] = '0;
        else if (BYP_M && we && rdi == rs[p]) exp_a[p] = wdata;
        else                                  exp_a[p] = ma[rs[p]];
      end
      if (we && rdi != 0) ma[rdi] = wdata;
    end
    if (!mrdy_b) begin
      foreach (exp_b[i]) exp_b[i] = '0;
      mb[clr_b] = '0;
      clr_b++;
      if (clr_b == 24) mrdy_b = 1'b1;
    end else begin
      for (int p = 0; p < 3; p++) begin
        if (rs[p] == 0 || int'(rs[p]) >= 24)  exp_b[p] = '0;
        else if (BYP_M && we && rdi == rs[p]) exp_b[p] = wdata[15:0];
        else                                  exp_b[p] = mb[rs[p]];
      end
      if (we && rdi != 0 && int'(rdi) < 24) mb[rdi] = wdata[15:0];
    end
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "/a_ready"}, {31'd0, rdy_a}, {31'd0, mrdy_a});
    check_eq({tag, "/b_ready"}, {31'd0, rdy_b}, {31'd0, mrdy_b});
    for (int p = 0; p < 2; p++)
      check_eq($sformatf("%s/a_port%0d", tag, p), rd_a[p*32 +: 32], exp_a[p]);
    for (int p = 0; p < 3; p++)
      check_eq($sformatf("%s/b_port%0d", tag, p), {16'd0, rd_b[p*16 +: 16]}, {16'd0, exp_b[p]});
  endtask

  task automatic step(input int r0, input int r1, input int r2, input bit w,
                      input int wa, input logic [31:0] wd, input string tag);
    rs[0] = AW'(r0); rs[1] = AW'(r1); rs[2] = AW'(r2);
    rsi_a = {rs[1], rs[0]};
    rsi_b = {rs[2], rs[1], rs[0]};
    we    = w;
    rdi   = AW'(wa);
    wdata = wd;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  initial begin
    rsi_a = '0; rsi_b = '0; rdi = '0; wdata = '0; we = 1'b0;
    foreach (ma[i]) ma[i] = 'x;
    foreach (mb[i]) mb[i] = 'x;
    model_reset();
    #2;
    check_outputs("reset");
    #1 rst_n = 1'b1;

    // Clear sequence; writes offered only while both instances are still clearing
    for (int i = 0; i < 32; i++)
      step($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
           (i < 24), $urandom_range(0, 31), $urandom, "clear");
    for (int i = 0; i < 32; i++) step(i, i, 31 - i, 1'b0, 0, 0, "read_zero");

    step(0, 0, 0, 1'b1, 5, 32'hDEADBEEF, "wr5");
    step(5, 5, 5, 1'b0, 0, 0, "rd5");
    check_eq("rd5_const_p0", rd_a[31:0], 32'hDEADBEEF);
    check_eq("rd5_const_p1", rd_a[63:32], 32'hDEADBEEF);

    step(0, 0, 0, 1'b1, 0, 32'h12345678, "wr0");
    step(0, 0, 0, 1'b0, 0, 0, "rd0");
    check_eq("rd0_const", rd_a[31:0], 32'h0);

    step(0, 0, 0, 1'b1, 7, 32'h11, "wr7_old");
    step(7, 3, 7, 1'b1, 7, 32'h22, "collide7");
    check_eq("collide_const", rd_a[31:0], BYP_M ? 32'h22 : 32'h11);
    step(7, 7, 7, 1'b0, 0, 0, "rd7_after");
    check_eq("rd7_after_const", rd_a[31:0], 32'h22);

    step(30, 30, 30, 1'b1, 30, 32'hCAFE, "wr30");
    step(30, 30, 30, 1'b0, 0, 0, "rd30");
    check_eq("b_oor_const", {16'd0, rd_b[15:0]}, 32'h0);
    step(0, 0, 0, 1'b1, 23, 32'hBEEF, "wr23");
    step(23, 23, 23, 1'b0, 0, 0, "rd23");
    for (int p = 0; p < 3; p++)
      check_eq($sformatf("b23_const_p%0d", p), {16'd0, rd_b[p*16 +: 16]}, 32'hBEEF);

    // Random traffic with frequent read/write collisions
    for (int i = 0; i < 400; i++) begin
      int wa;
      int r0;
      wa = $urandom_range(0, 31);
      r0 = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 31);
      step(r0, $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 1) == 1, wa, $urandom, "random");
    end

    // Asynchronous reset in the middle of operation
    step(0, 0, 0, 1'b1, 3, 32'hAA, "wr3");
    step(3, 3, 3, 1'b0, 0, 0, "rd3_pre");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    #2 rst_n = 1'b1;
    step(3, 3, 3, 1'b1, 3, 32'h55, "init_wr3");
    for (int i = 1; i < 32; i++) step(3, 3, 3, 1'b0, 0, 0, "reclear");
    step(3, 3, 3, 1'b0, 0, 0, "rd3_post");
    check_eq("rd3_post_const", rd_a[31:0], 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
